// File: rtl/blink_pkg.sv
// Shared types and constants for the blink decoder: FSM state encoding,
// element codes and the per-symbol element limit.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_e;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    localparam int MAX_ELEMS = 8;

endpackage

// File: rtl/blink_debounce.sv
// Pin conditioning for the blink decoder: 2-flop synchroniser followed by a
// stability filter. The filtered level follows the synchronised pin only after
// DEB_CYCLES consecutive differing samples, so both edges see the same delay
// and pulse widths are preserved. rise_o/fall_o are high for the first cycle
// at the new filtered level.
module blink_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q, fall_q;
    logic [DW-1:0] cnt_q;

    // Synchronise, then flip the filtered level after a run of DEB_CYCLES differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == DEB_LAST) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    fall_q  <= ~sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/blink_decoder.sv
// Blink pattern decoder: measures debounced high pulses as dots/dashes,
// packs up to MAX_ELEMS elements per symbol, ends a symbol on a long low gap
// and presents it on a valid/ready interface.
// Optional: define BLINK_DECODER_STATS_EN to add the sym_count output
// (saturating count of symbols accepted by the consumer).
module blink_decoder
    import blink_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 4,
    parameter int DOT_MAX    = 1000,
    parameter int DASH_MAX   = 4000,
    parameter int GAP_MIN    = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink_in,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic [7:0] sym_data,
    output logic [3:0] sym_len,
    output logic       sym_err,
    output logic       sym_ovf
`ifdef BLINK_DECODER_STATS_EN
    ,
    output logic [7:0] sym_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DOT_C   = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_MIN);
    localparam logic [3:0]       MAX_LEN = 4'(MAX_ELEMS);

    logic level, rise, fall;

    blink_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .din_i   (blink_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Run-length counter: on a filtered edge strobe it still holds the width
    // of the level just ended; it restarts at 1 for the new level.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: restart on either edge, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall)        cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // Run-length counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    logic   elem_bit, elem_long, emit;
    state_e state_q;
    logic [7:0] elem_q;
    logic [3:0] len_q;
    logic       err_q;

    assign elem_bit  = (cnt_q > DOT_C) ? ELEM_DASH : ELEM_DOT;
    assign elem_long = (cnt_q > DASH_C);
    assign emit      = (state_q == SPACE) && (cnt_q >= GAP_C);

    // Symbol assembly FSM: collect elements on falling edges, finish on a long gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    elem_q <= '0;
                    len_q  <= '0;
                    err_q  <= 1'b0;
                    // A one-cycle pulse (DEB_CYCLES=1) can rise during the emit
                    // cycle and fall here; capture it as the first element.
                    if (fall) begin
                        elem_q  <= 8'(elem_bit);
                        len_q   <= 4'd1;
                        err_q   <= elem_long;
                        state_q <= SPACE;
                    end else if (level) begin
                        state_q <= MARK;
                    end
                end
                MARK: begin
                    if (fall) begin
                        if (len_q < MAX_LEN) begin
                            elem_q[len_q[2:0]] <= elem_bit;
                            len_q              <= len_q + 4'd1;
                            err_q              <= err_q | elem_long;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= SPACE;
                    end
                end
                SPACE: begin
                    if (emit)       state_q <= IDLE;
                    else if (level) state_q <= MARK;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic       valid_q, ovf_q;
    logic [7:0] data_q;
    logic [3:0] slen_q;
    logic       serr_q;
    logic       accept;

    assign accept = valid_q & sym_ready;

    // Output holding register: load on emit when free (or freed this cycle), else flag a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            slen_q  <= '0;
            serr_q  <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (emit) begin
                if (!valid_q || sym_ready) begin
                    valid_q <= 1'b1;
                    data_q  <= elem_q;
                    slen_q  <= len_q;
                    serr_q  <= err_q;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sym_valid = valid_q;
    assign sym_data  = data_q;
    assign sym_len   = slen_q;
    assign sym_err   = serr_q;
    assign sym_ovf   = ovf_q;

`ifdef BLINK_DECODER_STATS_EN
    logic [7:0] count_q;

    // Saturating count of symbols handed to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          count_q <= '0;
        else if (accept && count_q != 8'hFF) count_q <= count_q + 8'd1;
    end

    assign sym_count = count_q;
`endif

endmodule

// File: tb/tb_blink_decoder.sv
// Directed testbench for blink_decoder (DEB_CYCLES=2, DOT_MAX=10,
// DASH_MAX=30, GAP_MIN=20). Pin is driven on negedges; outputs sampled on negedges.
module tb_blink_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       blink_in;
    logic       sym_ready;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic [3:0] sym_len;
    logic       sym_err;
    logic       sym_ovf;
`ifdef BLINK_DECODER_STATS_EN
    logic [7:0] sym_count;
`endif

    int tests = 0;
    int fails = 0;

    // Monitor state (written only by the monitor process)
    int         valid_cycles = 0;
    int         ovf_pulses   = 0;
    logic [7:0] cap_data     = '0;
    logic [3:0] cap_len      = '0;
    logic       cap_err      = 1'b0;

    always #5 clk = ~clk;

    blink_decoder #(
        .CNT_W(16), .DEB_CYCLES(2), .DOT_MAX(10), .DASH_MAX(30), .GAP_MIN(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .blink_in  (blink_in),
        .sym_ready (sym_ready),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_len   (sym_len),
        .sym_err   (sym_err),
        .sym_ovf   (sym_ovf)
`ifdef BLINK_DECODER_STATS_EN
        ,
        .sym_count (sym_count)
`endif
    );

    always @(negedge clk) begin
        if (sym_valid) begin
            valid_cycles = valid_cycles + 1;
            cap_data     = sym_data;
            cap_len      = sym_len;
            cap_err      = sym_err;
        end
        if (sym_ovf) ovf_pulses = ovf_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; blink_in = 1'b0; sym_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        blink_in = 1'b1;
        repeat (hi) @(negedge clk);
        blink_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; blink_in = 1'b0; sym_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            blink_in = ~blink_in;
        end
        @(negedge clk);
        tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sym_valid); end
        tests++; if (sym_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", sym_data); end
        tests++; if (sym_len !== 4'd0) begin fails++; $display("FAIL reset_len: got %0d want 0", sym_len); end
        tests++; if (sym_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", sym_err); end
        tests++; if (sym_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", sym_ovf); end
`ifdef BLINK_DECODER_STATS_EN
        tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", sym_count); end
`endif
    endtask

    task automatic test_reset_abort();
        int v0;
        do_reset();
        v0 = valid_cycles;
        blink_in = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        blink_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        tests++; if (valid_cycles - v0 !== 0) begin fails++; $display("FAIL reset_abort: got %0d valid cycles want 0", valid_cycles - v0); end
    endtask

    task automatic test_dot_dash();
        int v0, n;
        do_reset();
        v0 = valid_cycles;
        pulse(5, 8);
        blink_in = 1'b1;
        repeat (20) @(negedge clk);
        blink_in = 1'b0;
        n = 0;
        // Pin drops half a cycle before its first sampling edge; valid appears
        // 2 + DEB + GAP = 24 edges after that, i.e. at the 25th negedge.
        do begin
            @(negedge clk);
            n++;
        end while (!sym_valid && n < 40);
        tests++; if (n !== 25) begin fails++; $display("FAIL dd_latency: got %0d want 25", n); end
        tests++; if (sym_data !== 8'h02) begin fails++; $display("FAIL dd_data: got %h want 02", sym_data); end
        tests++; if (sym_len !== 4'd2) begin fails++; $display("FAIL dd_len: got %0d want 2", sym_len); end
        tests++; if (sym_err !== 1'b0) begin fails++; $display("FAIL dd_err: got %b want 0", sym_err); end
        repeat (10) @(negedge clk);
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL dd_count: got %0d valid cycles want 1", valid_cycles - v0); end
    endtask

    task automatic test_glitch();
        int v0;
        do_reset();
        v0 = valid_cycles;
        blink_in = 1'b1;
        @(negedge clk);
        blink_in = 1'b0;
        repeat (30) @(negedge clk);
        tests++; if (valid_cycles - v0 !== 0) begin fails++; $display("FAIL glitch: got %0d valid cycles want 0", valid_cycles - v0); end
    endtask

    task automatic test_elem_overflow();
        int v0;
        do_reset();
        v0 = valid_cycles;
        for (int i = 0; i < 9; i++) pulse(5, 8);
        repeat (35) @(negedge clk);
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL nine_count: got %0d want 1", valid_cycles - v0); end
        tests++; if (cap_data !== 8'h00) begin fails++; $display("FAIL nine_data: got %h want 00", cap_data); end
        tests++; if (cap_len !== 4'd8) begin fails++; $display("FAIL nine_len: got %0d want 8", cap_len); end
        tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL nine_err: got %b want 1", cap_err); end
    endtask

    task automatic test_long_pulse();
        int v0;
        do_reset();
        v0 = valid_cycles;
        pulse(40, 25);
        repeat (10) @(negedge clk);
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL long_count: got %0d want 1", valid_cycles - v0); end
        tests++; if (cap_data !== 8'h01) begin fails++; $display("FAIL long_data: got %h want 01", cap_data); end
        tests++; if (cap_len !== 4'd1) begin fails++; $display("FAIL long_len: got %0d want 1", cap_len); end
        tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL long_err: got %b want 1", cap_err); end
    endtask

    task automatic test_width_bounds();
        do_reset();
        // 10 -> dot, 11 -> dash, 30 -> dash without error
        pulse(10, 8);
        pulse(11, 8);
        pulse(30, 35);
        tests++; if (cap_data !== 8'h06) begin fails++; $display("FAIL bound_data: got %h want 06", cap_data); end
        tests++; if (cap_len !== 4'd3) begin fails++; $display("FAIL bound_len: got %0d want 3", cap_len); end
        tests++; if (cap_err !== 1'b0) begin fails++; $display("FAIL bound_err: got %b want 0", cap_err); end
        // 31 -> dash with error
        pulse(31, 35);
        tests++; if (cap_data !== 8'h01) begin fails++; $display("FAIL bound31_data: got %h want 01", cap_data); end
        tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL bound31_err: got %b want 1", cap_err); end
    endtask

    task automatic test_gap_bounds();
        int v0;
        do_reset();
        // low of 19 keeps one symbol
        v0 = valid_cycles;
        pulse(5, 19);
        pulse(5, 40);
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL gap19_count: got %0d want 1", valid_cycles - v0); end
        tests++; if (cap_len !== 4'd2) begin fails++; $display("FAIL gap19_len: got %0d want 2", cap_len); end
        // low of exactly 20 splits into two symbols
        v0 = valid_cycles;
        pulse(5, 20);
        pulse(5, 40);
        tests++; if (valid_cycles - v0 !== 2) begin fails++; $display("FAIL gap20_count: got %0d want 2", valid_cycles - v0); end
        tests++; if (cap_len !== 4'd1) begin fails++; $display("FAIL gap20_len: got %0d want 1", cap_len); end
    endtask

    task automatic test_backpressure();
        int o0;
        do_reset();
        sym_ready = 1'b0;
        o0 = ovf_pulses;
        pulse(5, 25);          // symbol A: one dot
        repeat (10) @(negedge clk);
        pulse(20, 25);         // symbol B: one dash, must be dropped
        repeat (10) @(negedge clk);
        tests++; if (ovf_pulses - o0 !== 1) begin fails++; $display("FAIL bp_ovf: got %0d pulses want 1", ovf_pulses - o0); end
        tests++; if (sym_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: got %b want 1", sym_valid); end
        tests++; if (sym_data !== 8'h00) begin fails++; $display("FAIL bp_hold_data: got %h want 00", sym_data); end
        tests++; if (sym_len !== 4'd1) begin fails++; $display("FAIL bp_hold_len: got %0d want 1", sym_len); end
        sym_ready = 1'b1;
        @(negedge clk);
        tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b want 0", sym_valid); end
`ifdef BLINK_DECODER_STATS_EN
        tests++; if (sym_count !== 8'd1) begin fails++; $display("FAIL bp_count: got %0d want 1", sym_count); end
`endif
    endtask

    initial begin
        rst = 1'b1; blink_in = 1'b0; sym_ready = 1'b0;
        test_reset();
        test_reset_abort();
        test_dot_dash();
        test_glitch();
        test_elem_overflow();
        test_long_pulse();
        test_width_bounds();
        test_gap_bounds();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
